muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
Multi-cycle sequencer for the EX-stage multiply/divide resource and owner of the HI/LO register pair. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, holds the pipeline via stall while the op runs, and commits the 64-bit result to HI/LO. Provides the architectural hilo value read by MFHI/MFLO in the ALU. Flush from the hazard unit aborts an in-flight op without updating HI/LO.

Parameters:
DATA_W, 32, operand width; HI/LO are 2*DATA_W.
MUL_STAGES, 1, extra cycles spent in MUL state (≥1).

Ports:
clk  in  1  clock
rst  in  1  reset; the polarity and synchronicity are fixed: synchronous, active-low
op_valid  in  1  EX holds a mul/div/move-to-HI/LO op
op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
src_a  in  DATA_W  rs value (dividend / multiplicand / MT source)
src_b  in  DATA_W  rt value
flush  in  1  abort EX-stage op
stall  out  1  hold IF..EX (combinational)
busy  out  1  FSM not IDLE (registered)
result_valid  out  1  one-cycle pulse when HI/LO written by mul/div
hilo  out  2*DATA_W  {HI,LO}, registered

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, hilo=0, result_valid=0, busy=0, counters/datapath regs=0. stall=0 while rst=0. Reset mid-operation aborts with no HI/LO update.
- States: IDLE, MUL, DIV, DONE.
- IDLE: op_valid & op∈{1..4} & !flush → latch operands/op, go MUL (1,2) or DIV (3,4); stall=1 that cycle.
- IDLE: op_valid & op∈{5,6} & !flush → next edge HI (5) or LO (6) := src_a; other half unchanged; no stall; stay IDLE.
- MUL: product computed from latched operands; MULT signed 64-bit, MULTU unsigned. After MUL_STAGES cycles → DONE. stall=1.
- DIV: restoring, 1 quotient bit/cycle on magnitudes, DATA_W iterations → DONE. stall=1. DIV signed: quotient negated if operand signs differ; remainder takes dividend's sign. DIVU unsigned.
- Divide by zero (src_b=0): no trap; still DATA_W cycles; LO=all ones, HI=dividend (raw src_a, both DIV and DIVU).
- DONE: HI:=high/remainder, LO:=low/quotient at this edge; result_valid=1 this cycle; stall=0 so pipeline advances; op inputs ignored this cycle (same instruction still in EX, must not restart); → IDLE.
- Timing: MULT stall high 1+MUL_STAGES cycles (default 2); DIV stall high DATA_W+1 cycles (33); hilo visible the cycle after DONE.
- Back-to-back: new op arriving in the cycle after DONE accepted normally from IDLE.
- flush in any state: stall=0 combinationally, next state IDLE, no HI/LO write, result_valid=0. flush in DONE suppresses the commit. flush in IDLE blocks MTHI/MTLO.
- stall = !flush & ((IDLE & op_valid & op∈{1..4}) | MUL | DIV).
- Operand changes while in MUL/DIV have no effect (latched).

Decomposition:
- Shared package/defines: op encoding constants (OP_NONE..OP_MTLO), state encodings, DATA_W default.
- One sub-module: div_iter (restoring unsigned divider: start, dividend, divisor → done, quotient, remainder, DATA_W cycles, abort input). Sign handling, multiplier and FSM stay in top.

Test Plan:
- Reset: rst=0 for 2 cycles with op_valid=1, op=DIV → hilo=0, stall=0, busy=0; release → IDLE.
- MULT src_a=0xFFFFFFFD, src_b=7 → stall high 2 cycles, result_valid pulse, hilo=0xFFFFFFFF_FFFFFFEB; MULTU same operands → hilo=0x00000006_FFFFFFEB.
- DIVU 100/7 → stall high 33 cycles, HI=0x00000002, LO=0x0000000E; immediately following DIV -7/2 (0xFFFFFFF9/2) → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 5/0 → 33 stall cycles, LO=0xFFFFFFFF, HI=0x00000005, no other effect.
- Load hilo=0x11111111_22222222, start DIV, flush at stall cycle 10 → stall 0 same cycle, busy 0 next, hilo unchanged, no result_valid; then MTHI 0x12345678 → hilo=0x12345678_22222222 next edge, no stall.
- DIV with rst=0 asserted at stall cycle 20 → hilo=0 next edge, state IDLE; MTLO 0xCAFEBABE afterwards → hilo=0x00000000_CAFEBABE.

Source files
------------

// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer and its divider.
package muldiv_hilo_ctrl_pkg;

   localparam int DATA_W_DEF = 32;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic op_is_mul(input logic [2:0] o);
      return (o == OP_MULT) || (o == OP_MULTU);
   endfunction

   function automatic logic op_is_div(input logic [2:0] o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle, DATA_W cycles.
module muldiv_hilo_ctrl_div_iter
   import muldiv_hilo_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(DATA_W);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] quo, rem, dvs;
   logic [DATA_W:0]   trial, diff;
   logic              q_bit;
   logic [DATA_W-1:0] rem_nxt;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      trial   = {rem, quo[DATA_W-1]};
      diff    = trial - {1'b0, dvs};
      q_bit   = ~diff[DATA_W];
      rem_nxt = q_bit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
      done    = (cnt == CNT_ONE);
   end

   // Iteration counter counts down; the step at count 1 is the last one.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
         quo <= '0;
         rem <= '0;
         dvs <= '0;
      end else if (abort) begin
         cnt <= '0;
      end else if (start) begin
         quo <= dividend;
         rem <= '0;
         dvs <= divisor;
         cnt <= CNT_INIT;
      end else if (cnt != '0) begin
         quo <= {quo[DATA_W-2:0], q_bit};
         rem <= rem_nxt;
         cnt <= cnt - CNT_ONE;
      end
   end

   assign quotient  = quo;
   assign remainder = rem;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/DIV sequencer that owns the HI/LO register pair.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | waiting; accepts mul/div, applies MTHI/MTLO
//   MUL     | product formed from latched operands
//   DIV     | divider iterating on operand magnitudes
//   DONE    | commit to HI/LO unless flushed, then back to IDLE
module muldiv_hilo_ctrl
   import muldiv_hilo_ctrl_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int MUL_STAGES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                op_valid,
   input  logic [2:0]          op,
   input  logic [DATA_W-1:0]   src_a,
   input  logic [DATA_W-1:0]   src_b,
   input  logic                flush,
   output logic                stall,
   output logic                busy,
   output logic                result_valid,
   output logic [2*DATA_W-1:0] hilo
);

   localparam int MCW = $clog2(MUL_STAGES + 1);
   localparam logic [MCW-1:0]    MUL_INIT = MCW'(MUL_STAGES);
   localparam logic [MCW-1:0]    MUL_ONE  = MCW'(1);
   localparam logic [DATA_W-1:0] ONE_W    = DATA_W'(1);

   state_t              state;
   logic [DATA_W-1:0]   a_lat, b_lat;
   logic                sgn_lat, neg_q, neg_r, div_zero, mul_lat;
   logic [MCW-1:0]      mul_cnt;
   logic [2*DATA_W-1:0] prod;

   logic                div_done;
   logic [DATA_W-1:0]   div_quo, div_rem;

   logic                is_mul_op, is_div_op, accept, div_start, a_neg, b_neg;
   logic [DATA_W-1:0]   mag_a, mag_b, quo_fix, rem_fix;
   logic [2*DATA_W-1:0] ext_a, ext_b, commit_val;

   // Accept decode, operand magnitudes, stall and result fix-up.
   always_comb begin
      is_mul_op    = op_is_mul(op);
      is_div_op    = op_is_div(op);
      accept       = rst & ~flush & op_valid & (state == ST_IDLE) & (is_mul_op | is_div_op);
      div_start    = accept & is_div_op;
      a_neg        = (op == OP_DIV) & src_a[DATA_W-1];
      b_neg        = (op == OP_DIV) & src_b[DATA_W-1];
      mag_a        = a_neg ? (~src_a + ONE_W) : src_a;
      mag_b        = b_neg ? (~src_b + ONE_W) : src_b;
      stall        = accept | (rst & ~flush & ((state == ST_MUL) | (state == ST_DIV)));
      result_valid = rst & ~flush & (state == ST_DONE);
      ext_a        = {{DATA_W{sgn_lat & a_lat[DATA_W-1]}}, a_lat};
      ext_b        = {{DATA_W{sgn_lat & b_lat[DATA_W-1]}}, b_lat};
      quo_fix      = neg_q ? (~div_quo + ONE_W) : div_quo;
      rem_fix      = neg_r ? (~div_rem + ONE_W) : div_rem;
      if (mul_lat)
         commit_val = prod;
      else if (div_zero)
         commit_val = {a_lat, {DATA_W{1'b1}}};
      else
         commit_val = {rem_fix, quo_fix};
   end

   muldiv_hilo_ctrl_div_iter #(.DATA_W(DATA_W)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .abort     (flush),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // Sequencer, operand latch and HI/LO ownership.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         hilo     <= '0;
         a_lat    <= '0;
         b_lat    <= '0;
         sgn_lat  <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         mul_lat  <= 1'b0;
         mul_cnt  <= '0;
         prod     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (op_valid && !flush) begin
                  if (is_mul_op || is_div_op) begin
                     a_lat    <= src_a;
                     b_lat    <= src_b;
                     sgn_lat  <= (op == OP_MULT) || (op == OP_DIV);
                     neg_q    <= a_neg ^ b_neg;
                     neg_r    <= a_neg;
                     div_zero <= (src_b == '0);
                     mul_lat  <= is_mul_op;
                     mul_cnt  <= MUL_INIT;
                     busy     <= 1'b1;
                     state    <= is_mul_op ? ST_MUL : ST_DIV;
                  end else if (op == OP_MTHI) begin
                     hilo[2*DATA_W-1:DATA_W] <= src_a;
                  end else if (op == OP_MTLO) begin
                     hilo[DATA_W-1:0] <= src_a;
                  end
               end
            end
            ST_MUL: begin
               if (flush) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  prod <= ext_a * ext_b;
                  if (mul_cnt == MUL_ONE)
                     state <= ST_DONE;
                  else
                     mul_cnt <= mul_cnt - MUL_ONE;
               end
            end
            ST_DIV: begin
               if (flush) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (div_done) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!flush)
                  hilo <= commit_val;
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Scoreboard bench for the HI/LO multiply/divide sequencer.
module tb_muldiv_hilo_ctrl;
   import muldiv_hilo_ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] src_a, src_b;
   logic        flush;
   logic        stall, busy, result_valid;
   logic [63:0] hilo;

   int          n_chk = 0;
   int          n_err = 0;
   logic [63:0] sb_q[$];
   logic [63:0] mdl_hilo;

   muldiv_hilo_ctrl #(.DATA_W(32), .MUL_STAGES(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .op_valid     (op_valid),
      .op           (op),
      .src_a        (src_a),
      .src_b        (src_b),
      .flush        (flush),
      .stall        (stall),
      .busy         (busy),
      .result_valid (result_valid),
      .hilo         (hilo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0;
      case (o)
         OP_MULT:  res = 64'(sa * sb);
         OP_MULTU: res = {32'b0, a} * {32'b0, b};
         OP_DIV: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         OP_DIVU: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   // Called just after a falling edge; returns just after the falling edge
   // following the commit, which is the earliest point a new op may be issued.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_stall);
      int          n_stall;
      bit          got;
      logic [63:0] want;
      n_stall  = 0;
      got      = 1'b0;
      op_valid = 1'b1;
      op       = o;
      src_a    = a;
      src_b    = b;
      sb_q.push_back(exp);
      for (int cyc = 0; cyc < 100 && !got; cyc++) begin
         #1;
         if (result_valid) begin
            got = 1'b1;
         end else begin
            if (stall) n_stall++;
            @(posedge clk);
            #1;
            src_a = $urandom;
            src_b = $urandom;
            @(negedge clk);
         end
      end
      if (!got) begin
         chk({tag, "_timeout"}, 64'd0, 64'd1);
         void'(sb_q.pop_front());
         op_valid = 1'b0;
         op       = OP_NONE;
      end else begin
         chk({tag, "_done_stall"}, 64'(stall), 64'd0);
         chk({tag, "_stall_cycles"}, 64'(n_stall), 64'(exp_stall));
         @(negedge clk);
         op_valid = 1'b0;
         op       = OP_NONE;
         #1;
         want     = sb_q.pop_front();
         mdl_hilo = want;
         chk({tag, "_hilo"}, hilo, want);
         chk({tag, "_rv_pulse"}, 64'(result_valid), 64'd0);
      end
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] a);
      op_valid = 1'b1;
      op       = o;
      src_a    = a;
      #1;
      chk("mt_stall", 64'(stall), 64'd0);
      @(negedge clk);
      op_valid = 1'b0;
      op       = OP_NONE;
      if (o == OP_MTHI) mdl_hilo[63:32] = a;
      else mdl_hilo[31:0] = a;
      #1;
      chk("mt_hilo", hilo, mdl_hilo);
   endtask

   task automatic watch_no_rv(input string tag, input int cycles);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         #1;
         if (result_valid) seen = 1'b1;
      end
      chk(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      logic [2:0]  r_op;
      logic [31:0] r_a, r_b;

      rst      = 1'b0;
      op_valid = 1'b1;
      op       = OP_DIV;
      src_a    = 32'd100;
      src_b    = 32'd7;
      flush    = 1'b0;
      mdl_hilo = '0;

      @(negedge clk);
      #1;
      chk("rst_stall_c1", 64'(stall), 64'd0);
      @(negedge clk);
      #1;
      chk("rst_hilo", hilo, 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rv", 64'(result_valid), 64'd0);
      rst      = 1'b1;
      op_valid = 1'b0;
      op       = OP_NONE;
      @(negedge clk);
      #1;
      chk("post_rst_busy", 64'(busy), 64'd0);

      run_op("mult",  OP_MULT,  32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 2);
      run_op("multu", OP_MULTU, 32'hFFFF_FFFD, 32'd7, 64'h0000_0006_FFFF_FFEB, 2);
      run_op("divu",  OP_DIVU,  32'd100,       32'd7, 64'h0000_0002_0000_000E, 33);
      run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
      run_op("div0",  OP_DIV,   32'd5,         32'd0, 64'h0000_0005_FFFF_FFFF, 33);

      for (int i = 0; i < 8; i++) begin
         r_op = 3'($urandom_range(1, 4));
         r_a  = $urandom;
         r_b  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
         if (i == 5) r_a = r_a | 32'h8000_0000;
         run_op("rand", r_op, r_a, r_b, ref_res(r_op, r_a, r_b),
                op_is_mul(r_op) ? 2 : 33);
      end

      // Flush mid-divide leaves HI/LO untouched.
      mt(OP_MTHI, 32'h1111_1111);
      mt(OP_MTLO, 32'h2222_2222);
      op_valid = 1'b1;
      op       = OP_DIV;
      src_a    = 32'd1000;
      src_b    = 32'd3;
      repeat (9) @(negedge clk);
      #1;
      chk("pre_flush_stall", 64'(stall), 64'd1);
      flush = 1'b1;
      #1;
      chk("flush_stall", 64'(stall), 64'd0);
      chk("flush_rv", 64'(result_valid), 64'd0);
      @(negedge clk);
      flush    = 1'b0;
      op_valid = 1'b0;
      op       = OP_NONE;
      #1;
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_hilo", hilo, 64'h1111_1111_2222_2222);
      watch_no_rv("flush_no_rv", 40);
      chk("flush_hilo_late", hilo, 64'h1111_1111_2222_2222);
      mt(OP_MTHI, 32'h1234_5678);
      chk("mthi_after_flush", hilo, 64'h1234_5678_2222_2222);

      // Flush in IDLE blocks a move-to.
      op_valid = 1'b1;
      op       = OP_MTLO;
      src_a    = 32'hDEAD_BEEF;
      flush    = 1'b1;
      @(negedge clk);
      flush    = 1'b0;
      op_valid = 1'b0;
      op       = OP_NONE;
      #1;
      chk("flush_blocks_mt", hilo, 64'h1234_5678_2222_2222);

      // Reset mid-divide clears HI/LO and returns to IDLE.
      op_valid = 1'b1;
      op       = OP_DIV;
      src_a    = 32'd77;
      src_b    = 32'd5;
      repeat (19) @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("mid_rst_stall", 64'(stall), 64'd0);
      @(negedge clk);
      rst      = 1'b1;
      op_valid = 1'b0;
      op       = OP_NONE;
      #1;
      chk("mid_rst_hilo", hilo, 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      mdl_hilo = '0;
      watch_no_rv("mid_rst_no_rv", 40);
      mt(OP_MTLO, 32'hCAFE_BABE);
      chk("mtlo_after_rst", hilo, 64'h0000_0000_CAFE_BABE);

      chk("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
